// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Cleans up the raw push-button pads before the game and selection logic
// (cursor movement, plant select) sees them. Each channel is handled on its
// own:
//   - a 2-flop synchroniser
//   - a debounce / auto-repeat FSM with a private timer
// Each channel produces:
//   - a clean level
//   - a one-cycle press pulse, repeated while held if auto-repeat is enabled
//   - a one-cycle release pulse
//
// Ports:
//   clk          system clock (100 MHz)
//   reset        asynchronous reset, active-high
//   btn_raw      raw, asynchronous, bouncy pad inputs; 1 = pressed
//   repeat_en    per-channel auto-repeat enable, sampled every cycle
//   btn_level    debounced level; 1 = pressed
//   btn_press    one-cycle pulse on accepted press and on each auto-repeat
//   btn_release  one-cycle pulse on accepted release
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int CNT_W           = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] PRESS_WAIT   = 3'd1;
    localparam logic [2:0] HELD         = 3'd2;
    localparam logic [2:0] REPEATING    = 3'd3;
    localparam logic [2:0] RELEASE_WAIT = 3'd4;

    // Each threshold is stored as "count minus one". The transition fires on
    // the edge that completes the count, so that the transition and the
    // registered output pulse land in the same update.
    localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST    = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST   = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] TIMER_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMER_MAX     = {CNT_W{1'b1}};

    logic [N_BTN-1:0] syncStage1;
    logic [N_BTN-1:0] syncStage2;

    // Two-flop synchroniser for all pads. The pads are fully asynchronous,
    // so nothing downstream may look at btn_raw directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncStage1 <= '0;
            syncStage2 <= '0;
        end else begin
            syncStage1 <= btn_raw;
            syncStage2 <= syncStage1;
        end
    end

    for (genvar ch = 0; ch < N_BTN; ch++) begin : gChannel
        logic [2:0]       state;
        logic [CNT_W-1:0] timer;
        logic [CNT_W-1:0] timerNext;
        logic             levelReg;
        logic             pressReg;
        logic             releaseReg;
        logic             syncBit;
        logic             repeatOn;

        assign syncBit  = syncStage2[ch];
        assign repeatOn = repeat_en[ch];

        // The timer saturates instead of wrapping. A wrap would let a stuck
        // count line up with a threshold a second time.
        assign timerNext = (timer == TIMER_MAX) ? timer : timer + TIMER_ONE;

        // Per-channel FSM. The pulse registers default to 0 every cycle, so a
        // pulse is exactly one clock wide. The level register only changes on
        // the same update that raises the matching press or release pulse.
        // A sync drop takes priority over repeat timing, so no repeat can fire
        // on the cycle the button starts to let go.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state      <= IDLE;
                timer      <= '0;
                levelReg   <= 1'b0;
                pressReg   <= 1'b0;
                releaseReg <= 1'b0;
            end else begin
                pressReg   <= 1'b0;
                releaseReg <= 1'b0;
                case (state)
                    IDLE: begin
                        if (syncBit) begin
                            state <= PRESS_WAIT;
                            timer <= TIMER_ONE;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!syncBit) begin
                            state <= IDLE;
                            timer <= '0;
                        end else if (timer >= DEBOUNCE_LAST) begin
                            state    <= HELD;
                            timer    <= '0;
                            pressReg <= 1'b1;
                            levelReg <= 1'b1;
                        end else begin
                            timer <= timerNext;
                        end
                    end
                    HELD: begin
                        if (!syncBit) begin
                            state <= RELEASE_WAIT;
                            timer <= TIMER_ONE;
                        end else if (!repeatOn) begin
                            timer <= '0;
                        end else if (timer >= DELAY_LAST) begin
                            state    <= REPEATING;
                            timer    <= '0;
                            pressReg <= 1'b1;
                        end else begin
                            timer <= timerNext;
                        end
                    end
                    REPEATING: begin
                        if (!syncBit) begin
                            state <= RELEASE_WAIT;
                            timer <= TIMER_ONE;
                        end else if (!repeatOn) begin
                            state <= HELD;
                            timer <= '0;
                        end else if (timer >= PERIOD_LAST) begin
                            timer    <= '0;
                            pressReg <= 1'b1;
                        end else begin
                            timer <= timerNext;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (syncBit) begin
                            state <= HELD;
                            timer <= '0;
                        end else if (timer >= DEBOUNCE_LAST) begin
                            state      <= IDLE;
                            timer      <= '0;
                            releaseReg <= 1'b1;
                            levelReg   <= 1'b0;
                        end else begin
                            timer <= timerNext;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        timer    <= '0;
                        levelReg <= 1'b0;
                    end
                endcase
            end
        end

        assign btn_level[ch]   = levelReg;
        assign btn_press[ch]   = pressReg;
        assign btn_release[ch] = releaseReg;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Self-checking bench for button_conditioner, built with small timing
// constants. The reference model works from the behaviour rules:
//   - sync is the raw input delayed by two clocks
//   - a level flips once sync has disagreed with it for DEB straight cycles
//   - repeats fire REPEAT_DELAY cycles after an anchor point, then every
//     REPEAT_PERIOD cycles
// Directed sequences add fixed expected pulse times on top of the model.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int N_BTN = 5;
    localparam int DEB   = 4;
    localparam int RDLY  = 10;
    localparam int RPER  = 3;
    localparam int CW    = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [N_BTN-1:0] btnRaw = '0;
    logic [N_BTN-1:0] repeatEn = '0;
    logic [N_BTN-1:0] btnLevel;
    logic [N_BTN-1:0] btnPress;
    logic [N_BTN-1:0] btnRelease;

    button_conditioner #(
        .N_BTN           (N_BTN),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RDLY),
        .REPEAT_PERIOD   (RPER),
        .CNT_W           (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btnRaw),
        .repeat_en   (repeatEn),
        .btn_level   (btnLevel),
        .btn_press   (btnPress),
        .btn_release (btnRelease)
    );

    always #5 clk = ~clk;

    int compareCount = 0;
    int failCount    = 0;

    // Reference model state
    logic [N_BTN-1:0] rawQ[$];
    logic [N_BTN-1:0] expLevel;
    logic [N_BTN-1:0] expPress;
    logic [N_BTN-1:0] expRelease;
    bit               lastSync[N_BTN];
    int               streak[N_BTN];
    int               age[N_BTN];
    int               target[N_BTN];
    bit               broken[N_BTN];

    // Random stimulus state
    int               segLeft[N_BTN];
    bit               curRaw[N_BTN];

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h required %0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        rawQ.delete();
        expLevel   = '0;
        expPress   = '0;
        expRelease = '0;
        for (int c = 0; c < N_BTN; c++) begin
            lastSync[c] = 1'b0;
            streak[c]   = 0;
            age[c]      = 0;
            target[c]   = RDLY;
            broken[c]   = 1'b0;
        end
    endtask

    // One clock edge of the reference model. raw/en are the values present
    // just before that edge.
    task automatic modelStep(input logic [N_BTN-1:0] raw,
                             input logic [N_BTN-1:0] en);
        logic [N_BTN-1:0] syncNow;
        bit s;
        rawQ.push_back(raw);
        if (rawQ.size() > 3) rawQ.delete(0);
        syncNow    = (rawQ.size() == 3) ? rawQ[0] : '0;
        expPress   = '0;
        expRelease = '0;
        for (int c = 0; c < N_BTN; c++) begin
            s = syncNow[c];
            if (s == lastSync[c]) streak[c]++;
            else streak[c] = 1;
            lastSync[c] = s;
            if (!expLevel[c]) begin
                if (s && streak[c] >= DEB) begin
                    expPress[c] = 1'b1;
                    expLevel[c] = 1'b1;
                    age[c]      = 0;
                    target[c]   = RDLY;
                    broken[c]   = 1'b0;
                end
            end else begin
                if (!s && streak[c] >= DEB) begin
                    expRelease[c] = 1'b1;
                    expLevel[c]   = 1'b0;
                end else if (!s) begin
                    broken[c] = 1'b1;
                end else if (broken[c] || !en[c]) begin
                    age[c]    = 0;
                    target[c] = RDLY;
                    broken[c] = 1'b0;
                end else begin
                    age[c]++;
                    if (age[c] == target[c]) begin
                        expPress[c] = 1'b1;
                        age[c]      = 0;
                        target[c]   = RPER;
                    end
                end
            end
        end
    endtask

    // Advance one clock, update the model, then compare just after the edge.
    task automatic stepCycle();
        @(posedge clk);
        modelStep(btnRaw, repeatEn);
        #1;
        checkOutput("level", 32'(btnLevel), 32'(expLevel));
        checkOutput("press", 32'(btnPress), 32'(expPress));
        checkOutput("release", 32'(btnRelease), 32'(expRelease));
    endtask

    // Assert reset between edges. Check that the outputs clear immediately and
    // stay clear across edges, then release reset away from an edge.
    task automatic doReset();
        #3;
        reset = 1'b1;
        #1;
        checkOutput("rst_level", 32'(btnLevel), 32'd0);
        checkOutput("rst_press", 32'(btnPress), 32'd0);
        checkOutput("rst_release", 32'(btnRelease), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_hold_level", 32'(btnLevel), 32'd0);
        #2;
        reset = 1'b0;
        modelReset();
    endtask

    // All buttons held through reset, auto-repeat only on channel 2. Fixed
    // expectations:
    //   - press on every channel at edge DEB+2
    //   - repeats on channel 2 at +RDLY, then every +RPER
    task automatic directedRun();
        logic [N_BTN-1:0] wantPress;
        for (int k = 1; k <= 24; k++) begin
            stepCycle();
            if (k == DEB + 2) wantPress = '1;
            else if (k == DEB + 2 + RDLY || k == DEB + 2 + RDLY + RPER ||
                     k == DEB + 2 + RDLY + 2 * RPER) wantPress = 5'b00100;
            else wantPress = '0;
            checkOutput("tp_press", 32'(btnPress), 32'(wantPress));
            checkOutput("tp_level", 32'(btnLevel),
                        (k >= DEB + 2) ? 32'h1f : 32'h0);
        end
    endtask

    // Random per-channel segments. Short segments (1..6) straddle the
    // debounce length to exercise glitch rejection. Long segments leave time
    // for auto-repeat. The repeat enables toggle occasionally.
    task automatic applyStimulus();
        for (int c = 0; c < N_BTN; c++) begin
            if (segLeft[c] == 0) begin
                curRaw[c]  = ~curRaw[c];
                segLeft[c] = ($urandom_range(0, 1) == 0) ?
                             int'($urandom_range(1, 6)) :
                             int'($urandom_range(8, 60));
            end
            segLeft[c]--;
            btnRaw[c] = curRaw[c];
            if ($urandom_range(0, 29) == 0) repeatEn[c] = ~repeatEn[c];
        end
    endtask

    initial begin
        modelReset();
        btnRaw   = 5'b11111;
        repeatEn = 5'b00100;
        #1;
        reset = 1'b1;
        #11;
        checkOutput("init_level", 32'(btnLevel), 32'd0);
        checkOutput("init_press", 32'(btnPress), 32'd0);
        checkOutput("init_release", 32'(btnRelease), 32'd0);
        reset = 1'b0;
        modelReset();

        directedRun();
        // Reset lands while channel 2 is repeating; the button stays held.
        doReset();
        directedRun();

        for (int c = 0; c < N_BTN; c++) begin
            curRaw[c]  = btnRaw[c];
            segLeft[c] = 0;
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            applyStimulus();
            stepCycle();
            if (cyc % 900 == 899) doReset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compareCount, failCount);
        $finish;
    end

endmodule
